seq_alu: RTL and testbench

Parametrised multi-cycle ALU for the next-generation CPU datapath. Covers the existing single-cycle operations (add, sub, and, or, pass) and adds iterative unsigned multiply, divide and remainder, behind a start/busy/done handshake. Results are registered, and Zero_o/Overflow_o are registered alongside them. The block sits between the register-file read stage and the write-back mux; the control unit stalls the PC while busy_o is high.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 139 +++++++++++++
 tb/tb_seq_alu.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result bus between the register-file read stage and seq_alu.
// The control side drives the request; the ALU drives the result and status.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data_o;
   logic             Zero_o;
   logic             Overflow_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output start_i, data1_i, data2_i, ALUCtrl_i,
      input  data_o, Zero_o, Overflow_o, busy_o, done_o
   );

   modport slave (
      input  start_i, data1_i, data2_i, ALUCtrl_i,
      output data_o, Zero_o, Overflow_o, busy_o, done_o
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/pass plus iterative unsigned
// multiply (shift-add) and divide/remainder (restoring), one bit per cycle.
module seq_alu #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic       clk_i,
   input logic       rst_i,
   seq_alu_if.slave  bus
);
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_DIVU = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] opa_q, opb_q, acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             zero_q, ovf_q;

   logic [WIDTH-1:0] sum, diff, result_d;
   logic             ovf_d, load_result, is_div_op;
   logic [WIDTH:0]   shifted, trial;

   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign is_div_op = (bus.ALUCtrl_i == OP_DIVU) || (bus.ALUCtrl_i == OP_REMU);

   // A zero divisor skips the iterative path and resolves in EXEC.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               if (bus.ALUCtrl_i == OP_MUL)                state_d = MUL;
               else if (is_div_op && bus.data2_i != '0)    state_d = DIV;
               else                                        state_d = EXEC;
            end
         end
         EXEC:     state_d = DONE;
         MUL, DIV: if (cnt_q == '0) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   assign load_result = (state_q == EXEC) ||
                        (((state_q == MUL) || (state_q == DIV)) && (cnt_q == '0));

   // acc_q holds the remainder and opa_q the dividend/quotient during a divide.
   assign shifted = {acc_q, opa_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, opb_q};

   always_comb begin
      sum      = opa_q + opb_q;
      diff     = opa_q - opb_q;
      result_d = opa_q;
      ovf_d    = 1'b0;
      case (op_q)
         OP_PASS: result_d = opa_q;
         OP_ADD: begin
            result_d = sum;
            ovf_d    = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum[WIDTH-1] != opa_q[WIDTH-1]);
         end
         OP_SUB: begin
            result_d = diff;
            ovf_d    = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (diff[WIDTH-1] != opa_q[WIDTH-1]);
         end
         OP_AND:  result_d = opa_q & opb_q;
         OP_OR:   result_d = opa_q | opb_q;
         OP_MUL:  result_d = acc_q;
         OP_DIVU: result_d = (state_q == DIV) ? opa_q : '1;
         OP_REMU: result_d = (state_q == DIV) ? acc_q : opa_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         op_q   <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  op_q  <= bus.ALUCtrl_i;
                  opa_q <= bus.data1_i;
                  opb_q <= bus.data2_i;
                  acc_q <= '0;
                  cnt_q <= CNT_W'(WIDTH);
               end
            end
            MUL: begin
               if (cnt_q != '0) begin
                  if (opb_q[0]) acc_q <= acc_q + opa_q;
                  opa_q <= opa_q << 1;
                  opb_q <= opb_q >> 1;
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DIV: begin
               if (cnt_q != '0) begin
                  acc_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                  opa_q <= {opa_q[WIDTH-2:0], ~trial[WIDTH]};
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
         if (load_result) begin
            data_q <= result_d;
            zero_q <= (result_d == '0);
            ovf_q  <= ovf_d;
         end
      end
   end

   assign bus.data_o     = data_q;
   assign bus.Zero_o     = zero_q;
   assign bus.Overflow_o = ovf_q;
   assign bus.busy_o     = (state_q == EXEC) || (state_q == MUL) || (state_q == DIV);
   assign bus.done_o     = (state_q == DONE);
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a 32-bit and an 8-bit instance share one
// stimulus stream, steered by sel8, and are compared against a plain-arithmetic model.
module tb_seq_alu;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [2:0]  op = '0;
   logic        sel8 = 1'b0;

   int errors = 0;
   int checks = 0;
   int lat = 0;
   int busy_cnt = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32)) if32 ();
   seq_alu_if #(.WIDTH(8))  if8 ();

   assign if32.start_i   = start & ~sel8;
   assign if32.data1_i   = a;
   assign if32.data2_i   = b;
   assign if32.ALUCtrl_i = op;
   assign if8.start_i    = start & sel8;
   assign if8.data1_i    = a[7:0];
   assign if8.data2_i    = b[7:0];
   assign if8.ALUCtrl_i  = op;

   seq_alu #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));
   seq_alu #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(if8));

   logic [31:0] obs_data;
   logic        obs_zero, obs_ovf, obs_busy, obs_done;
   assign obs_data = sel8 ? {24'd0, if8.data_o} : if32.data_o;
   assign obs_zero = sel8 ? if8.Zero_o     : if32.Zero_o;
   assign obs_ovf  = sel8 ? if8.Overflow_o : if32.Overflow_o;
   assign obs_busy = sel8 ? if8.busy_o     : if32.busy_o;
   assign obs_done = sel8 ? if8.done_o     : if32.done_o;

   // Returns {overflow, result} using true signed/unsigned arithmetic on w-bit values.
   function automatic logic [32:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y, input int w);
      logic [63:0] m, ux, uy, r;
      longint      sx, sy, sr, lim;
      logic        v;
      m   = (64'd1 << w) - 64'd1;
      ux  = {32'd0, x} & m;
      uy  = {32'd0, y} & m;
      lim = longint'(m >> 1);
      sx  = longint'(ux);
      sy  = longint'(uy);
      if (ux[w-1]) sx = sx - longint'(m) - 64'sd1;
      if (uy[w-1]) sy = sy - longint'(m) - 64'sd1;
      v = 1'b0;
      r = ux;
      case (f)
         3'b001: begin r = (ux + uy) & m; sr = sx + sy; v = (sr > lim) || (sr < -lim - 64'sd1); end
         3'b010: begin r = (ux - uy) & m; sr = sx - sy; v = (sr > lim) || (sr < -lim - 64'sd1); end
         3'b011: r = ux & uy;
         3'b100: r = ux | uy;
         3'b101: r = (ux * uy) & m;
         3'b110: r = (uy == 64'd0) ? m  : ux / uy;
         3'b111: r = (uy == 64'd0) ? ux : ux % uy;
         default: r = ux;
      endcase
      return {v, r[31:0]};
   endfunction

   // Edges from accept up to and including the one that raises done.
   function automatic int lat_of(input logic [2:0] f, input logic [31:0] y, input int w);
      logic [31:0] ym;
      ym = (w == 8) ? {24'd0, y[7:0]} : y;
      if (f == 3'b101 || ((f == 3'b110 || f == 3'b111) && ym != 32'd0)) return w + 2;
      return 2;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic waitDone(input int release_at);
      lat = 0;
      busy_cnt = 0;
      forever begin
         @(posedge clk); #1;
         lat++;
         if (lat == release_at) begin
            start = 1'b0;
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom);
         end
         if (obs_done || lat >= 200) break;
         if (obs_busy) busy_cnt++;
      end
   endtask

   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op = f;
      a = x;
      b = y;
      waitDone(1);
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] f, input logic [31:0] x,
                              input logic [31:0] y, input int exp_lat, input int exp_busy);
      logic [32:0] m;
      m = ref_model(f, x, y, sel8 ? 8 : 32);
      check({tag, ":latency"},      64'(lat),      64'(exp_lat));
      check({tag, ":busy_cycles"},  64'(busy_cnt), 64'(exp_busy));
      check({tag, ":busy_in_done"}, 64'(obs_busy), 64'd0);
      check({tag, ":data"},         64'(obs_data), 64'(m[31:0]));
      check({tag, ":zero"},         64'(obs_zero), 64'(m[31:0] == 32'd0));
      check({tag, ":overflow"},     64'(obs_ovf),  64'(m[32]));
      @(posedge clk); #1;
      check({tag, ":done_pulse"},   64'(obs_done), 64'd0);
      check({tag, ":data_hold"},    64'(obs_data), 64'(m[31:0]));
   endtask

   task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      int l;
      l = lat_of(f, y, sel8 ? 8 : 32);
      applyStimulus(f, x, y);
      checkOutput(tag, f, x, y, l, l - 1);
   endtask

   initial begin
      logic [2:0]  rf;
      logic [31:0] rx, ry;

      // Reset held with start high: nothing may start or complete.
      start = 1'b1; op = 3'b101; a = 32'd7; b = 32'd6;
      repeat (2) begin
         @(posedge clk); #1;
         check("reset:data", 64'(obs_data), 64'd0);
         check("reset:zero", 64'(obs_zero), 64'd1);
         check("reset:busy", 64'(obs_busy), 64'd0);
         check("reset:done", 64'(obs_done), 64'd0);
      end
      start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      $display("[TB] reset released");

      runOp("add_ovf", 3'b001, 32'h7FFF_FFFF, 32'd1);
      check("add_ovf:const", 64'(obs_data), 64'h8000_0000);
      check("add_ovf:const_ovf", 64'(obs_ovf), 64'd1);
      runOp("sub_zero", 3'b010, 32'd5, 32'd5);
      check("sub_zero:const_zero", 64'(obs_zero), 64'd1);
      runOp("sub_ovf", 3'b010, 32'h8000_0000, 32'd1);
      runOp("mul_7x6", 3'b101, 32'd7, 32'd6);
      check("mul_7x6:const", 64'(obs_data), 64'd42);
      runOp("mul_wrap", 3'b101, 32'hFFFF_FFFF, 32'd2);
      check("mul_wrap:const", 64'(obs_data), 64'hFFFF_FFFE);
      runOp("divu", 3'b110, 32'd100, 32'd7);
      check("divu:const", 64'(obs_data), 64'd14);
      runOp("remu", 3'b111, 32'd100, 32'd7);
      check("remu:const", 64'(obs_data), 64'd2);
      runOp("divu_by0", 3'b110, 32'd9, 32'd0);
      check("divu_by0:const", 64'(obs_data), 64'hFFFF_FFFF);
      runOp("remu_by0", 3'b111, 32'd9, 32'd0);
      check("remu_by0:const", 64'(obs_data), 64'd9);
      runOp("divu_big", 3'b110, 32'hFFFF_FFFF, 32'h8000_0001);
      runOp("and", 3'b011, 32'hF0F0, 32'hFF00);
      runOp("or", 3'b100, 32'h1234_0000, 32'h0000_5678);
      runOp("pass", 3'b000, 32'hDEAD_BEEF, 32'h1);

      // A second request mid-multiply must be ignored.
      start = 1'b1; op = 3'b101; a = 32'd7; b = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; op = 3'b000; a = 32'd99; b = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      waitDone(0);
      checkOutput("mul_restart", 3'b101, 32'd7, 32'd6, 27, 26);

      // Start held through done: accepted at the first IDLE edge after DONE.
      start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
      waitDone(1);
      check("b2b_first:data", 64'(obs_data), 64'd7);
      start = 1'b1; op = 3'b010; a = 32'd10; b = 32'd3;
      waitDone(2);
      checkOutput("b2b_second", 3'b010, 32'd10, 32'd3, 3, 1);

      // Reset in the tenth cycle of a divide aborts it without a done pulse.
      start = 1'b1; op = 3'b110; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort:busy", 64'(obs_busy), 64'd0);
      check("abort:done", 64'(obs_done), 64'd0);
      check("abort:data", 64'(obs_data), 64'd0);
      check("abort:zero", 64'(obs_zero), 64'd1);
      check("abort:ovf",  64'(obs_ovf),  64'd0);
      rst = 1'b1;
      runOp("and_after_abort", 3'b011, 32'hF0F0, 32'hFF00);
      check("and_after_abort:const", 64'(obs_data), 64'hF000);

      for (int i = 0; i < 30; i++) begin
         rf = 3'($urandom_range(0, 7));
         rx = $urandom;
         if ($urandom_range(0, 7) == 0)      ry = 32'd0;
         else if ($urandom_range(0, 1) == 1) ry = $urandom;
         else                                ry = 32'($urandom_range(1, 300));
         runOp($sformatf("rand32_%0d_op%0d", i, rf), rf, rx, ry);
      end

      sel8 = 1'b1;
      @(posedge clk); #1;
      runOp("w8_mul", 3'b101, 32'd15, 32'd17);
      check("w8_mul:const", 64'(obs_data), 64'hFF);
      runOp("w8_add_ovf", 3'b001, 32'h7F, 32'h1);
      check("w8_add_ovf:const", 64'(obs_data), 64'h80);
      check("w8_add_ovf:const_ovf", 64'(obs_ovf), 64'd1);
      runOp("w8_remu", 3'b111, 32'd200, 32'd13);
      for (int i = 0; i < 20; i++) begin
         rf = 3'($urandom_range(0, 7));
         rx = $urandom;
         ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         runOp($sformatf("rand8_%0d_op%0d", i, rf), rf, rx, ry);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
